// File: rtl/core_pkg.sv
// Shared core definitions: sequencer state encoding, instruction geometry and
// the opcode constants that the decode stage also uses.
package core_pkg;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2,
    HALT   = 2'd3
  } seq_state_t;

  localparam int DEF_M_WIDTH    = 8;
  localparam int DEF_INST_WIDTH = 32;
  localparam int INST_BYTES     = DEF_INST_WIDTH / DEF_M_WIDTH;

  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JAL    = 7'h6F;

  // Memory beats needed to fetch one instruction for a given geometry.
  function automatic int inst_bytes(input int inst_width, input int m_width);
    return inst_width / m_width;
  endfunction

endpackage

// File: rtl/fetch_assembler.sv
// Fetches one instruction as a sequence of byte reads and assembles it
// little-endian; the assembled word only updates when the last byte lands.
module fetch_assembler
  import core_pkg::*;
#(
  parameter int M_WIDTH    = 8,
  parameter int INST_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [M_WIDTH-1:0]    mem_rdata,
  input  logic                  mem_ack,
  output logic                  done,
  output logic [INST_WIDTH-1:0] inst
);

  localparam int BYTES = inst_bytes(INST_WIDTH, M_WIDTH);
  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  logic [IDX_W-1:0]      byte_idx;
  logic                  gap;
  logic [INST_WIDTH-1:0] asm_q;
  logic [INST_WIDTH-1:0] merged;
  logic                  accept;
  logic                  last;

  // Every byte is preceded by one idle cycle, including the first one after
  // entering FETCH, so a zero-wait fetch always costs 2*BYTES cycles.
  assign mem_req  = start & ~gap;
  assign mem_addr = base + ADDR_WIDTH'(byte_idx);
  assign accept   = mem_req & mem_ack;
  assign last     = (byte_idx == IDX_W'(BYTES - 1));
  assign done     = accept & last;

  always_comb begin
    merged = asm_q;
    merged[M_WIDTH*byte_idx +: M_WIDTH] = mem_rdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      byte_idx <= '0;
      gap      <= 1'b1;
      asm_q    <= '0;
      inst     <= '0;
    end else begin
      if (!start)
        gap <= 1'b1;
      else if (gap)
        gap <= 1'b0;
      else if (mem_ack)
        gap <= 1'b1;

      if (accept) begin
        asm_q <= merged;
        if (last) begin
          byte_idx <= '0;
          inst     <= merged;
        end else begin
          byte_idx <= byte_idx + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/inst_sequencer.sv
// Multi-cycle fetch/decode/execute/PC-update sequencer for the core.
// Optional single-step/halt support is enabled with INST_SEQ_STEP_EN.
module inst_sequencer
  import core_pkg::*;
#(
  parameter int                    M_WIDTH    = 8,
  parameter int                    INST_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [M_WIDTH-1:0]    mem_rdata,
  input  logic                  mem_ack,
  output logic [INST_WIDTH-1:0] inst,
  output logic                  dec_en,
  input  logic                  dec_ready,
  output logic                  ex_en,
  input  logic                  ex_done,
  input  logic                  branch_taken,
  input  logic [ADDR_WIDTH-1:0] branch_target,
  output logic [ADDR_WIDTH-1:0] pc
`ifdef INST_SEQ_STEP_EN
  ,
  input  logic                  halt_req,
  input  logic                  step
`endif
);

  localparam int BYTES = inst_bytes(INST_WIDTH, M_WIDTH);

  seq_state_t state;
  seq_state_t next_state;
  logic       first_q;
  logic       fetching;
  logic       fetch_done;

  assign fetching = (state == FETCH);

  fetch_assembler #(
    .M_WIDTH   (M_WIDTH),
    .INST_WIDTH(INST_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_fetch (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (fetching),
    .base     (pc),
    .mem_req  (mem_req),
    .mem_addr (mem_addr),
    .mem_rdata(mem_rdata),
    .mem_ack  (mem_ack),
    .done     (fetch_done),
    .inst     (inst)
  );

  // first_q marks the first cycle spent in a state, which gates the start pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= FETCH;
      first_q <= 1'b0;
      pc      <= RESET_PC;
    end else begin
      state   <= next_state;
      first_q <= (next_state != state);
      if (state == EXEC && ex_done)
        pc <= branch_taken ? (branch_target & ~ADDR_WIDTH'(3))
                           : pc + ADDR_WIDTH'(BYTES);
    end
  end

  always_comb begin
    next_state = state;
    dec_en     = 1'b0;
    ex_en      = 1'b0;
    unique case (state)
      FETCH: begin
        if (fetch_done)
          next_state = DECODE;
      end
      DECODE: begin
        dec_en = first_q;
        if (dec_ready)
          next_state = EXEC;
      end
      EXEC: begin
        ex_en = first_q;
        if (ex_done) begin
`ifdef INST_SEQ_STEP_EN
          next_state = halt_req ? HALT : FETCH;
`else
          next_state = FETCH;
`endif
        end
      end
      HALT: begin
`ifdef INST_SEQ_STEP_EN
        if (!halt_req || step)
          next_state = FETCH;
`else
        next_state = FETCH;
`endif
      end
      default: next_state = FETCH;
    endcase
  end

endmodule
